multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Parametrised Moore-style control FSM for the multicycle RV32I core. It replaces the single-cycle main decoder: it sequences instruction fetch, decode, execute, memory and writeback over several cycles, and drives every datapath enable and mux select. It adds jalr, lui, auipc, bne, a memory ready handshake and a sticky illegal-instruction trap.

## Interface
- MEM_HANDSHAKE, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready ignored (treated as 1)
- SUPPORT_JALR, 1: 0 = opcode 1100111 is illegal
- SUPPORT_UTYPE, 1: 0 = opcodes 0110111/0010111 are illegal

- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- op  in  7  instruction[6:0] from instruction register
- funct3  in  3  instruction[14:12]
- Zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  datapath enables/selects
- ResultSrc, ALUSrcA, ALUSrcB, ALUOp  out  2 each  mux selects / ALU decoder op
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- illegal  out  1  sticky illegal-instruction flag
- state  out  4  current state, debug

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL, JALR, LUI, TRAP.
- Every output not listed for a state is 0; no x outputs anywhere.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00; IRWrite=1 and PCUpdate=1 only when mem_ready; on mem_ready -> DECODE, else stay.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (OldPC+imm into ALUOut). Next: lw->MEMADR, sw->MEMADR, R->EXECUTER, I-ALU->EXECUTEI, branch->BRANCH, jal->JAL, jalr->JALR, lui->LUI, auipc->ALUWB, anything else->TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; lw->MEMREAD, sw->MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00; on mem_ready -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held until mem_ready; on mem_ready -> FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB. EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 -> ALUWB. This writes OldPC+4 to rd and ALUOut to PC.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (rs1+imm into ALUOut) -> JAL.
- LUI: ALUSrcA=11 (zero), ALUSrcB=01, ALUOp=00 -> ALUWB.
- TRAP: all enables 0, stays until reset. illegal sets on entry and stays 1 until reset.
- Branch funct3: 000 beq, 001 bne. Any other funct3 -> TRAP.
- PCWrite = PCUpdate | (Branch & (Zero ^ funct3[0])).
- ImmSrc is combinational from op: lw/I-ALU/jalr 000, sw 001, branch 010, jal 011, lui/auipc 100, others 000.

## Timing
- Reset edge: state=FETCH, illegal=0. While reset=1, IRWrite/PCWrite/MemWrite/RegWrite are forced to 0.
- All outputs except PCWrite, IRWrite and ImmSrc are pure functions of state.
- Zero-wait cycle counts: lw 5, sw 4, R 4, I-ALU 4, beq/bne 3, jal 4, jalr 5, lui 4, auipc 3.
- Each mem_ready=0 cycle in FETCH/MEMREAD/MEMWRITE adds exactly one cycle. MemWrite stays asserted and AdrSrc stays stable across wait cycles.
- Reset mid-instruction: aborts the instruction; a write enable asserted in that same cycle is suppressed.
- MEM_HANDSHAKE=0: a mem_ready=0 input has no effect on counts.

## Test plan
- lw, mem_ready held 1: states FETCH,DECODE,MEMADR,MEMREAD,MEMWB; RegWrite=1 only in cycle 5 with ResultSrc=01.
- sw, mem_ready low 2 cycles in MEMWRITE: MemWrite=1 for 3 consecutive cycles, AdrSrc=1 throughout, then FETCH.
- bne with Zero=0: PCWrite=1 in BRANCH. Same instruction with Zero=1: PCWrite=0. beq gives the opposite result.
- jalr: FETCH,DECODE,JALR,JAL,ALUWB; PCWrite=1 in JAL, RegWrite=1 in ALUWB; ImmSrc=000.
- op=0000000, then blt (funct3=100), then jalr with SUPPORT_JALR=0: each reaches TRAP; illegal=1 and stays 1, all enables 0; reset returns to FETCH with illegal=0.
- Reset asserted during MEMWRITE with mem_ready=1: MemWrite=0 that cycle, state=FETCH next cycle.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Moore-style control FSM for the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback and drives every datapath enable and mux select.
module multicycle_ctrl #(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit SUPPORT_JALR  = 1'b1,
    parameter bit SUPPORT_UTYPE = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        TRAP     = 4'd13
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t stateReg;
    state_t nextState;
    state_t decodeTarget;
    logic   memReady;
    logic   pcUpdate;
    logic   branch;
    logic   irWriteRaw;
    logic   memWriteRaw;
    logic   regWriteRaw;
    logic   branchTaken;

    // Without the handshake the memory is assumed to always finish in one cycle.
    assign memReady = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state    = stateReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= FETCH;
            illegal  <= 1'b0;
        end else begin
            stateReg <= nextState;
            if (nextState == TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    // Legal opcode -> first post-decode state; unsupported encodings trap.
    always_comb begin
        decodeTarget = TRAP;
        case (op)
            OP_LOAD:   decodeTarget = MEMADR;
            OP_STORE:  decodeTarget = MEMADR;
            OP_RTYPE:  decodeTarget = EXECUTER;
            OP_ITYPE:  decodeTarget = EXECUTEI;
            OP_BRANCH: decodeTarget = (funct3[2:1] == 2'b00) ? BRANCH : TRAP;
            OP_JAL:    decodeTarget = JAL;
            OP_JALR:   decodeTarget = SUPPORT_JALR ? JALR : TRAP;
            OP_LUI:    decodeTarget = SUPPORT_UTYPE ? LUI : TRAP;
            OP_AUIPC:  decodeTarget = SUPPORT_UTYPE ? ALUWB : TRAP;
            default:   decodeTarget = TRAP;
        endcase
    end

    always_comb begin
        nextState = stateReg;
        case (stateReg)
            FETCH:    nextState = memReady ? DECODE : FETCH;
            DECODE:   nextState = decodeTarget;
            MEMADR:   nextState = (op == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  nextState = memReady ? MEMWB : MEMREAD;
            MEMWB:    nextState = FETCH;
            MEMWRITE: nextState = memReady ? FETCH : MEMWRITE;
            EXECUTER: nextState = ALUWB;
            EXECUTEI: nextState = ALUWB;
            ALUWB:    nextState = FETCH;
            BRANCH:   nextState = FETCH;
            JAL:      nextState = ALUWB;
            JALR:     nextState = JAL;
            LUI:      nextState = ALUWB;
            TRAP:     nextState = TRAP;
            default:  nextState = FETCH;
        endcase
    end

    always_comb begin
        pcUpdate    = 1'b0;
        branch      = 1'b0;
        irWriteRaw  = 1'b0;
        memWriteRaw = 1'b0;
        regWriteRaw = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        case (stateReg)
            FETCH: begin
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                irWriteRaw = memReady;
                pcUpdate   = memReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR, JALR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                regWriteRaw = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc      = 1'b1;
                memWriteRaw = 1'b1;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcUpdate = 1'b1;
            end
            LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
            end
            default: begin
                pcUpdate = 1'b0;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BRANCH:        ImmSrc = 3'b010;
            OP_JAL:           ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    // bne inverts the sense of Zero; reset squashes any write issued in its cycle.
    assign branchTaken = branch & (Zero ^ funct3[0]);
    assign PCWrite     = (pcUpdate | branchTaken) & ~reset;
    assign IRWrite     = irWriteRaw & ~reset;
    assign MemWrite    = memWriteRaw & ~reset;
    assign RegWrite    = regWriteRaw & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through the FSM and
// compares state, sticky flag and packed control outputs against hand-derived values.
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] RTY   = 7'b0110011;
    localparam logic [6:0] BR    = 7'b1100011;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset, Zero, mem_ready;
    logic [6:0] op;
    logic [2:0] funct3;

    logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic [3:0] state;

    logic       PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2, illegal2;
    logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2;
    logic [2:0] ImmSrc2;
    logic [3:0] state2;

    logic [15:0] ctrl, ctrl2;
    int compared   = 0;
    int mismatched = 0;

    // Packed as {PCWrite,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc}.
    assign ctrl  = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
                    ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
    assign ctrl2 = {PCWrite2, AdrSrc2, IRWrite2, MemWrite2, RegWrite2,
                    ResultSrc2, ALUSrcA2, ALUSrcB2, ALUOp2, ImmSrc2};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .illegal(illegal), .state(state)
    );

    multicycle_ctrl #(
        .MEM_HANDSHAKE(1'b0), .SUPPORT_JALR(1'b0), .SUPPORT_UTYPE(1'b0)
    ) dut2 (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .IRWrite(IRWrite2),
        .MemWrite(MemWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2),
        .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .ImmSrc(ImmSrc2),
        .illegal(illegal2), .state(state2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [6:0] o, input logic [2:0] f3,
                                 input logic z, input logic rdy);
        reset     = rst;
        op        = o;
        funct3    = f3;
        Zero      = z;
        mem_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] expState,
                            input logic expIllegal, input logic [15:0] expCtrl);
        checkOutput({tag, ".state"}, {12'd0, state}, {12'd0, expState});
        checkOutput({tag, ".illegal"}, {15'd0, illegal}, {15'd0, expIllegal});
        checkOutput({tag, ".ctrl"}, ctrl, expCtrl);
    endtask

    task automatic checkDut2(input string tag, input logic [3:0] expState,
                             input logic expIllegal, input logic [15:0] expCtrl);
        checkOutput({tag, ".state2"}, {12'd0, state2}, {12'd0, expState});
        checkOutput({tag, ".illegal2"}, {15'd0, illegal2}, {15'd0, expIllegal});
        checkOutput({tag, ".ctrl2"}, ctrl2, expCtrl);
    endtask

    initial begin
        applyStimulus(1'b1, LW, 3'b010, 1'b0, 1'b1);
        tick();
        checkAll("rst", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_000);

        // lw with memory always ready
        applyStimulus(1'b0, LW, 3'b010, 1'b0, 1'b1);
        checkAll("lw_f", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_000);
        tick(); checkAll("lw_d", S_DECODE, 1'b0, 16'b0_0_0_0_0_00_01_01_00_000);
        tick(); checkAll("lw_ma", S_MEMADR, 1'b0, 16'b0_0_0_0_0_00_10_01_00_000);
        tick(); checkAll("lw_mr", S_MEMREAD, 1'b0, 16'b0_1_0_0_0_00_00_00_00_000);
        tick(); checkAll("lw_wb", S_MEMWB, 1'b0, 16'b0_0_0_0_1_01_00_00_00_000);
        tick();

        // sw with two wait cycles in MEMWRITE
        applyStimulus(1'b0, SW, 3'b010, 1'b0, 1'b1);
        checkAll("sw_f", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_001);
        tick(); checkAll("sw_d", S_DECODE, 1'b0, 16'b0_0_0_0_0_00_01_01_00_001);
        tick(); checkAll("sw_ma", S_MEMADR, 1'b0, 16'b0_0_0_0_0_00_10_01_00_001);
        tick();
        applyStimulus(1'b0, SW, 3'b010, 1'b0, 1'b0);
        checkAll("sw_w0", S_MEMWRITE, 1'b0, 16'b0_1_0_1_0_00_00_00_00_001);
        tick(); checkAll("sw_w1", S_MEMWRITE, 1'b0, 16'b0_1_0_1_0_00_00_00_00_001);
        tick();
        applyStimulus(1'b0, SW, 3'b010, 1'b0, 1'b1);
        checkAll("sw_w2", S_MEMWRITE, 1'b0, 16'b0_1_0_1_0_00_00_00_00_001);
        tick(); checkAll("sw_done", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_001);

        // R-type with a stalled fetch
        applyStimulus(1'b0, RTY, 3'b000, 1'b0, 1'b0);
        checkAll("r_stall", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_000);
        tick(); checkAll("r_stall2", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_000);
        applyStimulus(1'b0, RTY, 3'b000, 1'b0, 1'b1);
        checkAll("r_f", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_000);
        tick(); checkAll("r_d", S_DECODE, 1'b0, 16'b0_0_0_0_0_00_01_01_00_000);
        tick(); checkAll("r_ex", S_EXECUTER, 1'b0, 16'b0_0_0_0_0_00_10_00_10_000);
        tick(); checkAll("r_wb", S_ALUWB, 1'b0, 16'b0_0_0_0_1_00_00_00_00_000);
        tick();

        // bne / beq against both Zero values inside BRANCH
        applyStimulus(1'b0, BR, 3'b001, 1'b0, 1'b1);
        tick(); tick();
        checkAll("bne_z0", S_BRANCH, 1'b0, 16'b1_0_0_0_0_00_10_00_01_010);
        applyStimulus(1'b0, BR, 3'b001, 1'b1, 1'b1);
        checkAll("bne_z1", S_BRANCH, 1'b0, 16'b0_0_0_0_0_00_10_00_01_010);
        applyStimulus(1'b0, BR, 3'b000, 1'b1, 1'b1);
        checkAll("beq_z1", S_BRANCH, 1'b0, 16'b1_0_0_0_0_00_10_00_01_010);
        applyStimulus(1'b0, BR, 3'b000, 1'b0, 1'b1);
        checkAll("beq_z0", S_BRANCH, 1'b0, 16'b0_0_0_0_0_00_10_00_01_010);
        tick(); checkAll("br_done", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_010);

        // jalr
        applyStimulus(1'b0, JALR, 3'b000, 1'b0, 1'b1);
        tick(); checkAll("jalr_d", S_DECODE, 1'b0, 16'b0_0_0_0_0_00_01_01_00_000);
        tick(); checkAll("jalr_j", S_JALR, 1'b0, 16'b0_0_0_0_0_00_10_01_00_000);
        tick(); checkAll("jalr_jal", S_JAL, 1'b0, 16'b1_0_0_0_0_00_01_10_00_000);
        tick(); checkAll("jalr_wb", S_ALUWB, 1'b0, 16'b0_0_0_0_1_00_00_00_00_000);
        tick();

        // lui and auipc
        applyStimulus(1'b0, LUI, 3'b000, 1'b0, 1'b1);
        tick(); tick();
        checkAll("lui", S_LUI, 1'b0, 16'b0_0_0_0_0_00_11_01_00_100);
        tick(); checkAll("lui_wb", S_ALUWB, 1'b0, 16'b0_0_0_0_1_00_00_00_00_100);
        tick();
        applyStimulus(1'b0, AUIPC, 3'b000, 1'b0, 1'b1);
        tick(); tick();
        checkAll("auipc_wb", S_ALUWB, 1'b0, 16'b0_0_0_0_1_00_00_00_00_100);
        tick(); checkAll("auipc_done", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_100);

        // unknown opcode traps and stays trapped until reset
        applyStimulus(1'b0, 7'b0000000, 3'b000, 1'b0, 1'b1);
        tick(); checkAll("ill_d", S_DECODE, 1'b0, 16'b0_0_0_0_0_00_01_01_00_000);
        tick(); checkAll("ill_trap", S_TRAP, 1'b1, 16'b0);
        applyStimulus(1'b0, LW, 3'b010, 1'b1, 1'b1);
        tick(); checkAll("ill_stay", S_TRAP, 1'b1, 16'b0);
        applyStimulus(1'b1, LW, 3'b010, 1'b0, 1'b1);
        tick(); checkAll("ill_rst", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_000);

        // blt funct3 lies outside the beq/bne set and must trap
        applyStimulus(1'b0, BR, 3'b100, 1'b0, 1'b1);
        tick(); tick();
        checkAll("blt_trap", S_TRAP, 1'b1, 16'b0_0_0_0_0_00_00_00_00_010);
        applyStimulus(1'b1, BR, 3'b100, 1'b0, 1'b1);
        tick(); checkAll("blt_rst", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_010);

        // jalr on the variant without jalr support
        applyStimulus(1'b0, JALR, 3'b000, 1'b0, 1'b1);
        tick(); tick();
        checkDut2("nojalr", S_TRAP, 1'b1, 16'b0);
        checkAll("jalr_ok", S_JALR, 1'b0, 16'b0_0_0_0_0_00_10_01_00_000);

        // mem_ready low: ignored by the handshake-free variant, stalls the default one
        applyStimulus(1'b1, LW, 3'b010, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, LW, 3'b010, 1'b0, 1'b0);
        checkDut2("nohs_f", S_FETCH, 1'b0, 16'b1_0_1_0_0_10_00_10_00_000);
        tick(); tick(); tick(); tick();
        checkDut2("nohs_wb", S_MEMWB, 1'b0, 16'b0_0_0_0_1_01_00_00_00_000);
        checkAll("hs_stall", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_000);

        // reset during MEMWRITE suppresses the write in that same cycle
        applyStimulus(1'b1, SW, 3'b010, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, SW, 3'b010, 1'b0, 1'b1);
        tick(); tick(); tick();
        checkAll("sw_pre", S_MEMWRITE, 1'b0, 16'b0_1_0_1_0_00_00_00_00_001);
        applyStimulus(1'b1, SW, 3'b010, 1'b0, 1'b1);
        checkAll("rst_mw", S_MEMWRITE, 1'b0, 16'b0_1_0_0_0_00_00_00_00_001);
        tick(); checkAll("rst_after", S_FETCH, 1'b0, 16'b0_0_0_0_0_10_00_10_00_001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
